// File: rtl/llc_set_wb_seq_pkg.sv
// Shared LLC types for the set write-back sequencer.
// Holds default geometry, index types and the sequencer state enum.
package llc_set_wb_seq_pkg;

    localparam int LLC_WAYS     = 16;
    localparam int LLC_SET_BITS = 8;
    localparam int LLC_WAY_BITS = $clog2(LLC_WAYS);

    typedef logic [LLC_WAY_BITS-1:0] llc_way_t;
    typedef logic [LLC_SET_BITS-1:0] llc_set_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WAYS,
        WB_EVICT,
        WB_DONE
    } llc_wb_state_t;

    // A single-way set still needs a 1-bit way index.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/llc_set_wb_seq_if.sv
// Bundle between the LLC request FSM, the write-back sequencer and the arrays.
// slave: sequencer side; master: request FSM / array side.
interface llc_set_wb_seq_if
    import llc_set_wb_seq_pkg::*;
#(
    parameter int WAYS     = LLC_WAYS,
    parameter int SET_BITS = LLC_SET_BITS,
    parameter int WAY_BITS = way_bits(WAYS)
);

    logic                rst_state;
    logic                start_wb;
    logic [SET_BITS-1:0] set_in;
    logic [WAYS-1:0]     way_mod_mask;
    logic                evict_way_upd;
    logic                sram_ready;
    logic                wb_ready;
    logic                wr_en_way;
    logic                wr_en_evict_way;
    logic [WAY_BITS-1:0] wr_way;
    logic [SET_BITS-1:0] wr_set;
    logic                wb_done;
    logic                err_overlap;

    modport slave (
        input  rst_state, start_wb, set_in, way_mod_mask,
        input  evict_way_upd, sram_ready,
        output wb_ready, wr_en_way, wr_en_evict_way,
        output wr_way, wr_set, wb_done, err_overlap
    );

    modport master (
        output rst_state, start_wb, set_in, way_mod_mask,
        output evict_way_upd, sram_ready,
        input  wb_ready, wr_en_way, wr_en_evict_way,
        input  wr_way, wr_set, wb_done, err_overlap
    );

endinterface

// File: rtl/llc_set_wb_seq_prio_enc.sv
// Lowest-set-bit encoder over a way mask.
// Ports: mask in; idx = lowest set bit index (0 if empty); valid = |mask.
module llc_way_prio_enc #(
    parameter int WAYS     = 16,
    parameter int WAY_BITS = 4
) (
    input  logic [WAYS-1:0]     mask,
    output logic [WAY_BITS-1:0] idx,
    output logic                valid
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (mask[i]) idx = WAY_BITS'(i);
        end
    end

    assign valid = |mask;

endmodule

// File: rtl/llc_set_wb_seq.sv
// LLC per-set write-back sequencer: modified ways, then evict way, then done.
// Ports: clk, rst (async active-low), wb (slave modport of the bundle).
module llc_set_wb_seq
    import llc_set_wb_seq_pkg::*;
#(
    parameter int WAYS     = LLC_WAYS,
    parameter int SET_BITS = LLC_SET_BITS,
    parameter int WAY_BITS = way_bits(WAYS)
) (
    input  logic          clk,
    input  logic          rst,
    llc_set_wb_seq_if.slave wb
);

    llc_wb_state_t       state;
    logic [WAYS-1:0]     pend_mask;
    logic                evict_pend;
    logic [SET_BITS-1:0] wr_set_q;
    logic                err_q;
    logic [WAY_BITS-1:0] lo_idx;
    logic                lo_vld;

    llc_way_prio_enc #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_enc (
        .mask  (pend_mask),
        .idx   (lo_idx),
        .valid (lo_vld)
    );

    assign wb.wr_way          = lo_idx;
    assign wb.wr_set          = wr_set_q;
    assign wb.wr_en_way       = (state == WB_WAYS) && lo_vld && wb.sram_ready;
    assign wb.wr_en_evict_way = (state == WB_EVICT) && wb.sram_ready;
    assign wb.wb_ready        = (state == WB_IDLE);
    assign wb.wb_done         = (state == WB_DONE);
    assign wb.err_overlap     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= WB_IDLE;
            pend_mask  <= '0;
            evict_pend <= 1'b0;
            wr_set_q   <= '0;
            err_q      <= 1'b0;
        end else if (wb.rst_state) begin
            // Abort wins over any start in the same cycle.
            state      <= WB_IDLE;
            pend_mask  <= '0;
            evict_pend <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (wb.start_wb && state != WB_IDLE) err_q <= 1'b1;
            unique case (state)
                WB_IDLE: begin
                    if (wb.start_wb) begin
                        pend_mask  <= wb.way_mod_mask;
                        evict_pend <= wb.evict_way_upd;
                        wr_set_q   <= wb.set_in;
                        state      <= WB_WAYS;
                    end
                end
                WB_WAYS: begin
                    // Empty mask costs one check cycle with no write.
                    if (lo_vld) begin
                        if (wb.sram_ready)
                            pend_mask <= pend_mask & ~(WAYS'(1) << lo_idx);
                    end else begin
                        state <= evict_pend ? WB_EVICT : WB_DONE;
                    end
                end
                WB_EVICT: begin
                    if (wb.sram_ready) begin
                        evict_pend <= 1'b0;
                        state      <= WB_DONE;
                    end
                end
                WB_DONE: state <= WB_IDLE;
            endcase
        end
    end

endmodule
